// File: rtl/uart_wb_bridge_pkg.sv
// Shared types and protocol constants for the UART-to-Wishbone bridge.
package uart_wb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_DATA      = 3'd2,
        ST_BUS       = 3'd3,
        ST_RESP      = 3'd4,
        ST_RESP_WAIT = 3'd5
    } bridge_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/uart_wb_bridge.sv
// Byte-stream command decoder acting as a single-transfer Wishbone initiator.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              tx_en_o,
    output logic [BYTE_W-1:0] tx_data_o,
    input  logic              tx_busy_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [WORD_W-1:0] addr_o,
    output logic [WORD_W-1:0] data_o,
    input  logic [WORD_W-1:0] data_i,
    input  logic              ack_i,
    output logic              busy_o
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t     state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        rsp_cnt_q, rsp_cnt_d;
    logic              wait_q, wait_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [WORD_W-1:0] resp_q, resp_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              tx_en_q, tx_en_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        wait_d     = wait_q;
        to_cnt_d   = to_cnt_q;
        resp_d     = resp_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        tx_en_d    = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
                    we_d       = (rx_data_i == CMD_WRITE);
                    byte_cnt_d = 2'd0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_valid_i) begin
                    addr_d     = {addr_q[23:0], rx_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (we_q) begin
                            byte_cnt_d = 2'd0;
                            state_d    = ST_DATA;
                        end else begin
                            cyc_d    = 1'b1;
                            stb_d    = 1'b1;
                            to_cnt_d = '0;
                            state_d  = ST_BUS;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    data_d     = {data_q[23:0], rx_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        cyc_d    = 1'b1;
                        stb_d    = 1'b1;
                        to_cnt_d = '0;
                        state_d  = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (ack_i && cyc_q) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_RESP;
                    if (we_q) begin
                        resp_d    = {RSP_OK, 24'h000000};
                        rsp_cnt_d = 2'd0;
                    end else begin
                        resp_d    = data_i;
                        rsp_cnt_d = 2'd3;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    resp_d    = {RSP_ERR, 24'h000000};
                    rsp_cnt_d = 2'd0;
                    state_d   = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (!tx_busy_i) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = resp_q[31:24];
                    resp_d    = {resp_q[23:0], 8'h00};
                    wait_d    = 1'b0;
                    state_d   = ST_RESP_WAIT;
                end
            end
            ST_RESP_WAIT: begin
                // First cycle is unconditional so a busy flag that rises late is still seen.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (!tx_busy_i) begin
                    if (rsp_cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_cnt_d = rsp_cnt_q - 2'd1;
                        state_d   = ST_RESP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            rsp_cnt_q  <= 2'd0;
            wait_q     <= 1'b0;
            to_cnt_q   <= '0;
            resp_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            wait_q     <= wait_d;
            to_cnt_q   <= to_cnt_d;
            resp_q     <= resp_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign busy_o    = busy_q;

endmodule
